ysyx_22041211_lsu_mem_slave: RTL and testbench
==============================================

// Module: ysyx_22041211_lsu_mem_slave
// PURPOSE
//  Memory responder (data-side slave) for the LSU's load/store requests: accepts one request via valid/ready,
//  models LATENCY cycles of access delay, performs byte-masked write or word read on an internal array,
//  returns response via valid/ready. Sits between the LSU and data storage; one outstanding request max.
// PARAMETERS
//  DATA_LEN   32           data/address width
//  DEPTH      1024         array depth in 32-bit words
//  BASE_ADDR  32'h80000000 byte address of word 0
//  LATENCY    2            cycles from accept to response (0 allowed)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset; asynchronous and active-high
//  req_valid  in   1   LSU request valid
//  req_ready  out  1   slave can accept a request
//  req_wen    in   1   1=store, 0=load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSB-aligned (byte 0 = data[7:0])
//  req_wmask  in   4   size mask relative to addr: 4'b0001 byte, 4'b0011 half, 4'b1111 word
//  rsp_valid  out  1   response valid
//  rsp_ready  in   1   LSU accepts response
//  rsp_rdata  out  32  load data, shifted right so addressed byte is at [7:0]; 0 for stores
//  rsp_err    out  1   address outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//   Array contents are NOT reset. Request latch cleared; any uncommitted write dropped.
//  States: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid&&req_ready at posedge: latch wen/addr/wdata/wmask;
//     LATENCY==0 -> perform access at this edge, go RESP; else counter<=LATENCY-1, go WAIT.
//   WAIT: req_ready=0. counter!=0 -> counter-1, stay. counter==0 -> perform access at this edge, go RESP.
//   RESP: req_ready=0, rsp_valid=1; rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready at posedge -> IDLE.
//     rsp_valid drops the cycle after handshake; next request accepted no earlier than that cycle.
//  Access: off=addr[1:0]; idx=(addr-BASE_ADDR)>>2 (32-bit subtract, unsigned compare for range).
//   Out of range: rsp_err=1, rsp_rdata=0, no array write.
//   Store: lane mask = (wmask<<off)[3:0], lane data = (wdata<<(8*off))[31:0]; bytes past lane 3 discarded
//     (misaligned crossing truncated, no err). Only enabled lanes of word idx updated. rsp_rdata=0.
//   Load: rsp_rdata = array[idx] >> (8*off), zero-filled; wmask ignored. Sign/zero extension is LSU's job.
//  Array read for a load happens at the access edge, so a store's update is visible to the next load.
//  req_* inputs only sampled at accept edge; changes during WAIT/RESP ignored.
//  rsp_valid never asserts without a preceding accepted request; exactly one response per request.
//  Total latency: accept edge -> rsp_valid high after LATENCY+1 edges (LATENCY=0: next cycle).
//  Reset asserted in WAIT/RESP: immediate return to IDLE, rsp_valid=0, pending response lost.
// TESTING
//  1 Reset: rst=1 mid-cycle -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 without waiting for clk.
//  2 SW 0x80000010 <= 0xDEADBEEF, then LW 0x80000010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 3 edges after accept (LATENCY=2).
//  3 After test 2, SB addr 0x80000011 data 0x000000AA mask 4'b0001, LW 0x80000010 -> 0xDEADAAEF;
//    LH 0x80000012 -> rsp_rdata=0x0000DEAD.
//  4 LW 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> rsp_err=1, rsp_rdata=0; SW there leaves array unchanged.
//  5 Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored;
//    rsp_ready=1 -> handshake, IDLE next cycle.
//  6 Reset during WAIT of SW 0x80000020 <= 0x12345678 (old 0x0) -> no response; later LW 0x80000020 -> 0x00000000.

Source files
------------

// File: rtl/ysyx_22041211_lsu_mem_slave.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_lsu_mem_slave
//
// Data-side memory responder for the LSU. It accepts one load/store request,
// models a fixed access latency, performs a byte-masked store or a word load
// on an internal word array, and returns one response. Only one request can
// be outstanding at a time.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. The producer holds valid and its
// payload stable until that edge. req_ready is high only in IDLE. rsp_valid
// is high only in RESP, and rsp_rdata/rsp_err do not change while it is high.
//
// Ports
//   clk        in   1          clock, all state on posedge
//   rst        in   1          asynchronous active-high reset
//   req_valid  in   1          request valid
//   req_ready  out  1          slave can accept a request (IDLE)
//   req_wen    in   1          1 = store, 0 = load
//   req_addr   in   DATA_LEN   byte address
//   req_wdata  in   DATA_LEN   store data, LSB-aligned
//   req_wmask  in   4          size mask relative to addr (0001/0011/1111)
//   rsp_valid  out  1          response valid (RESP)
//   rsp_ready  in   1          LSU accepts the response
//   rsp_rdata  out  DATA_LEN   load data shifted so addressed byte is [7:0]
//   rsp_err    out  1          address outside the array window
//   dbg_state  out  2          current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ----------------------------------------------------------------------------
module ysyx_22041211_lsu_mem_slave #(
  parameter int                   DATA_LEN  = 32,
  parameter int                   DEPTH     = 1024,
  parameter logic [DATA_LEN-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int                   LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [DATA_LEN-1:0]  req_addr,
  input  logic [DATA_LEN-1:0]  req_wdata,
  input  logic [3:0]           req_wmask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_LEN-1:0]  rsp_rdata,
  output logic                 rsp_err,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [DATA_LEN-1:0] SPAN = DATA_LEN'(4 * DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wen;
  logic [DATA_LEN-1:0]   r_addr;
  logic [DATA_LEN-1:0]   r_wdata;
  logic [3:0]            r_wmask;
  logic [DATA_LEN-1:0]   r_rdata;
  logic                  r_err;
  logic [DATA_LEN-1:0]   r_mem [DEPTH];

  // With zero latency the access happens on the accept edge itself, so the
  // access datapath looks at the live request in IDLE and the latch otherwise.
  logic                  w_sel_req;
  logic                  w_acc_wen;
  logic [DATA_LEN-1:0]   w_acc_addr;
  logic [DATA_LEN-1:0]   w_acc_wdata;
  logic [3:0]            w_acc_wmask;
  logic [DATA_LEN-1:0]   w_rel;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_off;
  logic [4:0]            w_shamt;
  logic [3:0]            w_lane_mask;
  logic [DATA_LEN-1:0]   w_lane_data;
  logic                  w_access;
  logic                  w_do_write;
  logic [DATA_LEN-1:0]   w_rdata_nxt;
  logic                  w_err_nxt;

  assign w_sel_req   = (r_state == S_IDLE);
  assign w_acc_wen   = w_sel_req ? req_wen   : r_wen;
  assign w_acc_addr  = w_sel_req ? req_addr  : r_addr;
  assign w_acc_wdata = w_sel_req ? req_wdata : r_wdata;
  assign w_acc_wmask = w_sel_req ? req_wmask : r_wmask;

  // Wrap-around subtract: addresses below BASE_ADDR become huge and fail the
  // unsigned range compare, so one compare covers both ends of the window.
  assign w_rel      = w_acc_addr - BASE_ADDR;
  assign w_in_range = (w_rel < SPAN);
  assign w_idx      = w_rel[IDX_W+1:2];
  assign w_off      = w_acc_addr[1:0];
  assign w_shamt    = {w_off, 3'b000};

  // Lanes shifted past byte 3 fall off: misaligned stores are truncated.
  assign w_lane_mask = 4'(w_acc_wmask << w_off);
  assign w_lane_data = w_acc_wdata << w_shamt;

  assign w_access = (r_state == S_IDLE && req_valid && LATENCY == 0) ||
                    (r_state == S_WAIT && r_cnt == '0);
  // rst gate keeps a write from landing on an edge where reset is asserted.
  assign w_do_write = !rst && w_access && w_acc_wen && w_in_range;

  assign w_err_nxt   = !w_in_range;
  assign w_rdata_nxt = (w_in_range && !w_acc_wen) ? (r_mem[w_idx] >> w_shamt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            if (LATENCY == 0) begin
              r_rdata <= w_rdata_nxt;
              r_err   <= w_err_nxt;
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_22041211_lsu_mem_slave.sv
module tb_ysyx_22041211_lsu_mem_slave;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int          LATENCY   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Byte-addressed reference image of the array window.
  logic [7:0] mdl_b [4*DEPTH];

  // Scoreboard of expected responses, one per request.
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  ysyx_22041211_lsu_mem_slave #(
    .DATA_LEN (32),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .LATENCY  (LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference model: byte-level view of the memory window.
  task automatic model_access(input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              output logic [31:0] rdata, output logic err);
    longint rel;
    int     base_byte;
    int     off;
    rel   = longint'(addr) - longint'(BASE_ADDR);
    rdata = 32'h0;
    err   = 1'b0;
    if (rel < 0 || rel >= 4 * DEPTH) begin
      err = 1'b1;
      return;
    end
    off       = int'(rel) % 4;
    base_byte = int'(rel) - off;
    for (int i = 0; i < 4; i++) begin
      if (off + i < 4) begin
        if (wen) begin
          if (wmask[i]) mdl_b[base_byte + off + i] = wdata[8*i +: 8];
        end else begin
          rdata[8*i +: 8] = mdl_b[base_byte + off + i];
        end
      end
    end
  endtask

  // Driver: one full request/response transaction with optional backpressure.
  task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold);
    logic [31:0] e_rd;
    logic        e_er;
    logic [31:0] held_rd;
    int          lat;
    model_access(wen, addr, wdata, wmask, e_rd, e_er);
    exp_q.push_back(e_rd);
    exp_err_q.push_back(e_er);

    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    chk({tag, ".req_ready_idle"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
    chk({tag, ".req_ready_busy"}, {31'b0, req_ready}, 32'd0);

    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(LATENCY));

    e_rd = exp_q.pop_front();
    e_er = exp_err_q.pop_front();
    if (rsp_valid) begin
      chk({tag, ".rdata"}, rsp_rdata, e_rd);
      chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, e_er});
      held_rd = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".hold_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, ".hold_rdata"}, rsp_rdata, held_rd);
        chk({tag, ".hold_req_ready"}, {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, ".rsp_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
      chk({tag, ".req_ready_back"}, {31'b0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wd;
    int          sel;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b0;

    // Test 1: asynchronous reset, outputs settle before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err",   {31'b0, rsp_err},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Give the words used below known contents.
    for (int w = 0; w < 32; w++) begin
      do_req("init", 1'b1, BASE_ADDR + 32'(4*w), 32'h0, 4'hF, 0);
    end
    do_req("init_top", 1'b1, BASE_ADDR + 32'(4*(DEPTH-1)), 32'h0, 4'hF, 0);

    // Test 2: word store then word load.
    do_req("sw_10", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_req("lw_10", 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0);

    // Test 3: byte store into lane 1, then word and halfword loads.
    do_req("sb_11", 1'b1, 32'h8000_0011, 32'h0000_00AA, 4'b0001, 0);
    do_req("lw_10b", 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0);
    do_req("lh_12", 1'b0, 32'h8000_0012, 32'h0, 4'b0011, 0);
    chk("t3.model_word", {mdl_b[19], mdl_b[18], mdl_b[17], mdl_b[16]}, 32'hDEAD_AAEF);

    // Test 4: accesses just outside both ends of the window.
    do_req("lw_low",  1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, 0);
    do_req("lw_high", 1'b0, 32'h8000_1000, 32'h0, 4'hF, 0);
    do_req("sw_low",  1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 0);
    do_req("sw_high", 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 0);
    do_req("lw_w0",   1'b0, 32'h8000_0000, 32'h0, 4'hF, 0);
    do_req("lw_wtop", 1'b0, BASE_ADDR + 32'(4*(DEPTH-1)), 32'h0, 4'hF, 0);

    // Test 5: response backpressure for 3 cycles with a stray request.
    do_req("bp_lw_10", 1'b0, 32'h8000_0010, 32'h0, 4'hF, 3);

    // Test 6: reset while the store is still in WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6.in_wait", {31'b0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t6.rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("t6.no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    do_req("t6.lw_20", 1'b0, 32'h8000_0020, 32'h0, 4'hF, 0);

    // Randomized mix of loads/stores, sizes, offsets and out-of-range hits.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = BASE_ADDR - 32'($urandom_range(1, 64));
      else if (sel == 1) addr = BASE_ADDR + 32'(4*DEPTH) + 32'($urandom_range(0, 64));
      else               addr = BASE_ADDR + 32'($urandom_range(0, 127));
      case ($urandom_range(0, 2))
        0:       mask = 4'b0001;
        1:       mask = 4'b0011;
        default: mask = 4'b1111;
      endcase
      wd = $urandom;
      do_req("rand", 1'($urandom_range(0, 1)), addr, wd, mask, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    n_err++;
    $display("FAIL timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
